// File: rtl/mips_seq_pkg.sv
// Shared types and decode helpers for the MIPS multi-cycle sequencer.
package mips_seq_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    EXEC1  = 3'd1,
    EXEC2  = 3'd2,
    HALT   = 3'd3,
    MDWAIT = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_LOAD  = 3'd1,
    CLS_STORE = 3'd2,
    CLS_MULT  = 3'd3,
    CLS_DIV   = 3'd4
  } instr_class_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SWL     = 6'h2a;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] OP_SWR     = 6'h2e;

  function automatic instr_class_t instr_class(input logic [31:0] ir);
    instr_class_t cls;
    cls = CLS_ALU;
    case (ir[31:26])
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: cls = CLS_LOAD;
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR:                 cls = CLS_STORE;
      OP_SPECIAL: begin
        case (ir[5:0])
          FN_MULT, FN_MULTU: cls = CLS_MULT;
          FN_DIV, FN_DIVU:   cls = CLS_DIV;
          default:           cls = CLS_ALU;
        endcase
      end
      default: cls = CLS_ALU;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mips_seq_countdown.sv
// Loadable down-counter that parks at zero; times the multiply/divide wait.
module mips_seq_countdown #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Count register: load has priority over decrement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= value;
    end else if (dec && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/mips_sequencer.sv
// Multi-cycle FETCH/EXEC1/EXEC2/HALT sequencer with optional MDWAIT state,
// compiled in when MIPS_SEQ_MDWAIT_EN is defined.
module mips_sequencer
  import mips_seq_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instr_i,
  input  logic [31:0]         pc_i,
  input  logic                waitrequest,
  output logic [2:0]          state_o,
  output logic [31:0]         ir_o,
  output logic                mem_read,
  output logic                mem_write,
  output logic                pc_en,
  output logic                md_busy,
  output logic                halted,
  output logic [RETIRE_W-1:0] retire_count
);

  state_t                state_r, next_state_s;
  logic [31:0]           ir_r;
  logic [RETIRE_W-1:0]   retire_r;
  logic                  ir_load_s, mem_read_s, mem_write_s, pc_en_s, md_busy_s;

`ifdef MIPS_SEQ_MDWAIT_EN
  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAX_CYC == 0) ? 1 : $clog2(MAX_CYC + 1);
  // The counter holds "cycles remaining minus one", so N cycles load N-1.
  localparam logic [CW-1:0] MULT_LD = (MULT_CYCLES > 0) ? CW'(MULT_CYCLES - 1) : {CW{1'b0}};
  localparam logic [CW-1:0] DIV_LD  = (DIV_CYCLES > 0)  ? CW'(DIV_CYCLES - 1)  : {CW{1'b0}};

  logic          cnt_load_s, cnt_dec_s, cnt_zero_s;
  logic [CW-1:0] cnt_val_s;

  mips_seq_countdown #(.W(CW)) u_countdown (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load_s),
    .dec   (cnt_dec_s),
    .value (cnt_val_s),
    .zero  (cnt_zero_s)
  );
`endif

  // State, instruction and retire-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= FETCH;
      ir_r     <= 32'h0000_0000;
      retire_r <= {RETIRE_W{1'b0}};
    end else begin
      state_r  <= next_state_s;
      ir_r     <= ir_load_s ? instr_i : ir_r;
      retire_r <= pc_en_s ? (retire_r + RETIRE_W'(1'b1)) : retire_r;
    end
  end

  // Next-state and Moore-style control decode.
  always_comb begin
    next_state_s = state_r;
    ir_load_s    = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    pc_en_s      = 1'b0;
    md_busy_s    = 1'b0;
`ifdef MIPS_SEQ_MDWAIT_EN
    cnt_load_s   = 1'b0;
    cnt_dec_s    = 1'b0;
    cnt_val_s    = {CW{1'b0}};
`endif
    case (state_r)
      FETCH: begin
        if (pc_i == 32'h0000_0000) begin
          next_state_s = HALT;
        end else begin
          mem_read_s = 1'b1;
          if (!waitrequest) begin
            ir_load_s    = 1'b1;
            next_state_s = EXEC1;
          end else begin
            next_state_s = FETCH;
          end
        end
      end
      EXEC1: begin
        case (instr_class(ir_r))
          CLS_LOAD: begin
            mem_read_s = 1'b1;
            if (!waitrequest) begin
              next_state_s = EXEC2;
            end else begin
              next_state_s = EXEC1;
            end
          end
          CLS_STORE: begin
            mem_write_s = 1'b1;
            if (!waitrequest) begin
              pc_en_s      = 1'b1;
              next_state_s = FETCH;
            end else begin
              next_state_s = EXEC1;
            end
          end
`ifdef MIPS_SEQ_MDWAIT_EN
          CLS_MULT: begin
            if (MULT_CYCLES > 0) begin
              cnt_load_s   = 1'b1;
              cnt_val_s    = MULT_LD;
              next_state_s = MDWAIT;
            end else begin
              pc_en_s      = 1'b1;
              next_state_s = FETCH;
            end
          end
          CLS_DIV: begin
            if (DIV_CYCLES > 0) begin
              cnt_load_s   = 1'b1;
              cnt_val_s    = DIV_LD;
              next_state_s = MDWAIT;
            end else begin
              pc_en_s      = 1'b1;
              next_state_s = FETCH;
            end
          end
`endif
          default: begin
            pc_en_s      = 1'b1;
            next_state_s = FETCH;
          end
        endcase
      end
      EXEC2: begin
        pc_en_s      = 1'b1;
        next_state_s = FETCH;
      end
`ifdef MIPS_SEQ_MDWAIT_EN
      MDWAIT: begin
        md_busy_s = 1'b1;
        if (cnt_zero_s) begin
          pc_en_s      = 1'b1;
          next_state_s = FETCH;
        end else begin
          cnt_dec_s    = 1'b1;
          next_state_s = MDWAIT;
        end
      end
`endif
      HALT:    next_state_s = HALT;
      default: next_state_s = FETCH;
    endcase
  end

  assign state_o      = state_r;
  assign ir_o         = ir_r;
  assign retire_count = retire_r;
  assign mem_read     = mem_read_s;
  assign mem_write    = mem_write_s;
  assign pc_en        = pc_en_s;
  assign md_busy      = md_busy_s;
  assign halted       = (state_r == HALT);

endmodule

// File: doc/mips_sequencer.md
# mips_sequencer

Registered multi-cycle sequencer for the MIPS CPU. It owns the FETCH/EXEC1/EXEC2/HALT state register, latches the fetched instruction, and stalls on memory `waitrequest`. It extends the sequence with a parametrised MDWAIT state so multiply/divide can take a configurable number of cycles. It drives the instruction decoder's `state` input and gates the PC counter enable, and it also exposes a retired-instruction counter.

## Interface
- `MULT_CYCLES`, default 4: cycles MULT/MULTU spend in MDWAIT; 0 skips MDWAIT.
- `DIV_CYCLES`, default 32: cycles DIV/DIVU spend in MDWAIT; 0 skips MDWAIT.
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `instr_i`  in  32  memory read data; sampled in FETCH when `waitrequest`=0.
- `pc_i`  in  32  current PC.
- `waitrequest`  in  1  memory busy.
- `state_o`  out  3  current state (encoding in package).
- `ir_o`  out  32  latched instruction.
- `mem_read`  out  1  read request (FETCH, and EXEC1 of loads).
- `mem_write`  out  1  write request (EXEC1 of stores).
- `pc_en`  out  1  one-cycle PC advance pulse; marks retirement.
- `md_busy`  out  1  high while in MDWAIT.
- `halted`  out  1  high in HALT.
- `retire_count`  out  RETIRE_W  instructions retired since reset.

## Operation
- Reset values: state FETCH; `ir_o`=0; `retire_count`=0; MDWAIT counter 0. All outputs low except `mem_read`, which is 1 while in FETCH with `pc_i`≠0.
- FETCH:
  - If `pc_i`==0, go to HALT. `mem_read` is low and takes priority over `waitrequest`.
  - Otherwise `mem_read`=1. While `waitrequest`=1, stay in FETCH with IR unchanged.
  - When `waitrequest`=0, load IR from `instr_i` and go to EXEC1.
- EXEC1, instruction class decoded from `ir_o`:
  - Load: `mem_read`=1. Stay while `waitrequest`=1; otherwise go to EXEC2.
  - Store: `mem_write`=1. Stay while `waitrequest`=1; otherwise pulse `pc_en` and go to FETCH.
  - MULT/MULTU/DIV/DIVU with latency N>0: load the counter with N-1 and go to MDWAIT. There is no `pc_en` in this cycle.
  - All others, including mult/div with N=0: pulse `pc_en` and go to FETCH.
- EXEC2: pulse `pc_en`, then go to FETCH.
- MDWAIT:
  - `md_busy`=1 and the counter decrements each cycle.
  - In the cycle the counter reads 0, pulse `pc_en` and go to FETCH. MDWAIT therefore lasts exactly N cycles.
  - `waitrequest` is ignored.
- HALT is sticky and leaves only on reset. In HALT, `mem_read`, `mem_write` and `pc_en` stay low.
- `retire_count` increments on every `pc_en` and wraps modulo 2^RETIRE_W.
- Counter width is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1), minimum 1.
- An asserted reset at any point, including mid-MDWAIT or mid-stall, returns immediately to FETCH and discards the in-progress instruction.

## Timing
- Latencies with `waitrequest`=0 throughout:
  - ALU, branch, jump and store: 2 cycles (FETCH, EXEC1).
  - Load: 3 cycles.
  - Mult/div: 2+N cycles.
- Each `waitrequest` cycle adds one cycle to the state it occurs in.
- `pc_en` is registered-state-decoded (a Moore output of the current state plus `waitrequest`) and is never high for two consecutive cycles.
- IR updates on the rising edge that leaves FETCH. `ir_o` is stable for the whole instruction.
- `halted` rises on the edge after FETCH sees `pc_i`==0.

## Configuration
- `MIPS_SEQ_MDWAIT_EN` defined: MDWAIT behaviour as specified above.
- `MIPS_SEQ_MDWAIT_EN` undefined:
  - MDWAIT state and counter are not compiled.
  - Mult/div retire in EXEC1 as 2-cycle instructions, regardless of `MULT_CYCLES`/`DIV_CYCLES`.
  - `md_busy` is tied to 0.

## Structure
- Package `mips_seq_pkg`:
  - `state_t` enum: FETCH=3'd0, EXEC1=3'd1, EXEC2=3'd2, HALT=3'd3, MDWAIT=3'd4.
  - Opcode/fncode constants for SPECIAL, MULT, MULTU, DIV, DIVU, the load opcodes and the store opcodes.
  - Function `instr_class(ir)` returning the enum {ALU, LOAD, STORE, MULT, DIV}.
- Sub-module `mips_seq_countdown`: loadable down-counter with `load`, `value`, `zero` signals, parametrised width.

## Test plan
- ADDU (0x00851021) at PC 0xBFC00000, `waitrequest`=0: states FETCH, EXEC1; `pc_en` in cycle 2; `retire_count` goes 0→1.
- LW with `waitrequest` high for 3 cycles in EXEC1: `mem_read` held 3+1 cycles; EXEC2 follows; total 6 cycles; single `pc_en`.
- DIV with DIV_CYCLES=32: `md_busy` high for exactly 32 cycles; `pc_en` on the 32nd; total 34 cycles. Repeat with DIV_CYCLES=0: 2 cycles, `md_busy` never high.
- `pc_i`=0 in FETCH with `waitrequest`=1: `mem_read`=0; `halted`=1 next cycle and stays high for 100 cycles.
- Reset asserted at MDWAIT cycle 10: asynchronous return to FETCH, `retire_count`=0, `ir_o`=0; after release, a new fetch retires normally.
- Build without `MIPS_SEQ_MDWAIT_EN`: MULT retires in 2 cycles and `md_busy` stays 0.
